// File: rtl/wb_axi_addr_arbiter.sv
// Round-robin arbiter sharing one Wishbone->AXI address-channel converter
// among NUM_REQ Wishbone requesters, with an in-flight transaction limit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no address presented; pick next eligible requester if a slot is free
// S_GRANT | winner's address/ID presented downstream, waiting for m_addr_ready
// S_GAP   | one cycle with m_stb low so the converter settles back to idle
module wb_axi_addr_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_cyc,
    input  logic [NUM_REQ-1:0]            req_stb,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          m_cyc,
    output logic                          m_stb,
    output logic [ADDR_WIDTH-1:0]         m_adr,
    output logic [ID_WIDTH-1:0]           m_id,
    input  logic                          m_addr_ready,
    input  logic                          resp_done,
    output logic [2:0]                    outstanding,
    output logic                          busy,
    output logic                          err_underflow
);

    localparam int         IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   m_adr_q, m_adr_d;
    logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
    logic                    m_stb_q, m_stb_d;
    logic [2:0]              outst_q, outst_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      elig;
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic                    accept;

    assign elig   = req_cyc & req_stb;
    assign accept = (state_q == S_GRANT) && m_addr_ready;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        int c;
        pick_found = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!pick_found && elig[c[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = c[IDX_W-1:0];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            m_adr_q   <= '0;
            m_id_q    <= '0;
            m_stb_q   <= 1'b0;
            outst_q   <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            m_adr_q   <= m_adr_d;
            m_id_q    <= m_id_d;
            m_stb_q   <= m_stb_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    // Next-state, grant latching and in-flight counter.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        m_adr_d   = m_adr_q;
        m_id_d    = m_id_q;
        m_stb_d   = m_stb_q;
        outst_d   = outst_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found && (outst_q < MAX_OUT)) begin
                    state_d   = S_GRANT;
                    gnt_idx_d = pick_idx;
                    m_adr_d   = req_adr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    m_id_d    = ID_WIDTH'(pick_idx);
                    m_stb_d   = 1'b1;
                end
            end
            S_GRANT: begin
                if (m_addr_ready) begin
                    ptr_d   = gnt_idx_q;
                    m_stb_d = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                m_stb_d = 1'b0;
            end
        endcase

        // A simultaneous acceptance and response leave the count unchanged.
        if (accept && !resp_done) begin
            outst_d = outst_q + 3'd1;
        end else if (!accept && resp_done) begin
            if (outst_q == 3'd0) err_d = 1'b1;
            else                 outst_d = outst_q - 3'd1;
        end
    end

    // Outputs: ack is combinational on the downstream handshake.
    always_comb begin
        req_ack = '0;
        if (accept) req_ack[gnt_idx_q] = 1'b1;
        m_cyc         = m_stb_q;
        m_stb         = m_stb_q;
        m_adr         = m_adr_q;
        m_id          = m_id_q;
        outstanding   = outst_q;
        err_underflow = err_q;
        busy          = (state_q != S_IDLE) || (outst_q != 3'd0);
    end

endmodule

// File: tb/tb_wb_axi_addr_arbiter.sv
// Scoreboard bench for wb_axi_addr_arbiter with two requesters.
module tb_wb_axi_addr_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int IW = 4;

    logic             ACLK;
    logic             ARESETN;
    logic [NR-1:0]    req_cyc;
    logic [NR-1:0]    req_stb;
    logic [NR*AW-1:0] req_adr;
    logic [NR-1:0]    req_ack;
    logic             m_cyc;
    logic             m_stb;
    logic [AW-1:0]    m_adr;
    logic [IW-1:0]    m_id;
    logic             m_addr_ready;
    logic             resp_done;
    logic [2:0]       outstanding;
    logic             busy;
    logic             err_underflow;

    wb_axi_addr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_cyc(req_cyc), .req_stb(req_stb), .req_adr(req_adr), .req_ack(req_ack),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_adr(m_adr), .m_id(m_id),
        .m_addr_ready(m_addr_ready), .resp_done(resp_done),
        .outstanding(outstanding), .busy(busy), .err_underflow(err_underflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] adr;
    } exp_t;

    exp_t sb[$];
    int   ack_times[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc_cnt = 0;
    int   ack_cnt = 0;
    exp_t mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_resp();
        resp_done = 1'b1;
        tick();
        resp_done = 1'b0;
    endtask

    always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

    // Every acceptance is compared against the oldest expected grant.
    always @(negedge ACLK) begin
        if (ARESETN && (req_ack != '0)) begin
            ack_times.push_back(cyc_cnt);
            ack_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 64'(req_ack), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_onehot", 64'(req_ack), 64'd1 << mon_e.id);
                chk("ack_m_id", 64'(m_id), 64'(mon_e.id));
                chk("ack_m_adr", 64'(m_adr), 64'(mon_e.adr));
            end
        end
    end

    initial begin
        int n_hi;
        int a0;
        ARESETN      = 1'b0;
        req_cyc      = '0;
        req_stb      = '0;
        req_adr      = '0;
        m_addr_ready = 1'b0;
        resp_done    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_m_stb", 64'(m_stb), 64'd0);
        chk("rst_m_cyc", 64'(m_cyc), 64'd0);
        chk("rst_m_adr", 64'(m_adr), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_req_ack", 64'(req_ack), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        ARESETN = 1'b1;
        tick();

        // Single requester 0, ready two cycles after m_stb
        req_adr[31:0] = 32'h1000;
        req_cyc = 2'b01;
        req_stb = 2'b01;
        sb.push_back('{id: 4'd0, adr: 32'h1000});
        tick();
        chk("t1_m_stb_latency", 64'(m_stb), 64'd1);
        chk("t1_m_cyc", 64'(m_cyc), 64'd1);
        chk("t1_m_adr", 64'(m_adr), 64'h1000);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        tick();
        chk("t1_m_stb_held", 64'(m_stb), 64'd1);
        m_addr_ready = 1'b1;
        tick();
        m_addr_ready = 1'b0;
        req_cyc = '0;
        req_stb = '0;
        chk("t1_gap_m_stb", 64'(m_stb), 64'd0);
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        chk("t1_ack_cnt", 64'(ack_cnt), 64'd1);
        tick();
        chk("t1_idle_m_stb", 64'(m_stb), 64'd0);
        pulse_resp();
        chk("t1_drain", 64'(outstanding), 64'd0);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // Fairness: both eligible, ready always high, from fresh reset
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();
        req_adr[31:0]  = 32'hA000;
        req_adr[63:32] = 32'hB000;
        sb.push_back('{id: 4'd0, adr: 32'hA000});
        sb.push_back('{id: 4'd1, adr: 32'hB000});
        sb.push_back('{id: 4'd0, adr: 32'hA000});
        sb.push_back('{id: 4'd1, adr: 32'hB000});
        ack_times.delete();
        req_cyc = 2'b11;
        req_stb = 2'b11;
        m_addr_ready = 1'b1;
        n_hi = 0;
        repeat (12) begin
            tick();
            if (m_stb) n_hi++;
        end
        req_cyc = '0;
        req_stb = '0;
        m_addr_ready = 1'b0;
        chk("t3_stb_windows", 64'(n_hi), 64'd4);
        chk("t3_outstanding", 64'(outstanding), 64'd4);
        chk("t3_ack_count", 64'(ack_times.size()), 64'd4);
        if (ack_times.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("t3_spacing", 64'(ack_times[i] - ack_times[i-1]), 64'd3);
        end
        repeat (4) pulse_resp();
        chk("t3_drain", 64'(outstanding), 64'd0);

        // Outstanding limit: five requests, fourth fills the window
        req_adr[31:0] = 32'h2000;
        for (int i = 0; i < 5; i++) sb.push_back('{id: 4'd0, adr: 32'h2000});
        a0 = ack_cnt;
        req_cyc = 2'b01;
        req_stb = 2'b01;
        m_addr_ready = 1'b1;
        repeat (15) tick();
        chk("t4_acks_full", 64'(ack_cnt - a0), 64'd4);
        chk("t4_blocked_stb", 64'(m_stb), 64'd0);
        chk("t4_full", 64'(outstanding), 64'd4);
        pulse_resp();
        chk("t4_freed_stb", 64'(m_stb), 64'd0);
        chk("t4_freed_cnt", 64'(outstanding), 64'd3);
        tick();
        chk("t4_fifth_stb", 64'(m_stb), 64'd1);
        tick();
        req_cyc = '0;
        req_stb = '0;
        m_addr_ready = 1'b0;
        chk("t4_refull", 64'(outstanding), 64'd4);
        chk("t4_acks_total", 64'(ack_cnt - a0), 64'd5);

        // Acceptance and response in the same cycle at outstanding=2
        pulse_resp();
        pulse_resp();
        chk("t5_pre", 64'(outstanding), 64'd2);
        a0 = ack_cnt;
        req_adr[63:32] = 32'hB000;
        sb.push_back('{id: 4'd1, adr: 32'hB000});
        req_cyc = 2'b10;
        req_stb = 2'b10;
        tick();
        chk("t5_m_stb", 64'(m_stb), 64'd1);
        chk("t5_m_id", 64'(m_id), 64'd1);
        m_addr_ready = 1'b1;
        resp_done = 1'b1;
        tick();
        m_addr_ready = 1'b0;
        resp_done = 1'b0;
        req_cyc = '0;
        req_stb = '0;
        chk("t5_net_zero", 64'(outstanding), 64'd2);
        chk("t5_ack", 64'(ack_cnt - a0), 64'd1);

        // Underflow
        pulse_resp();
        pulse_resp();
        chk("t6_zero", 64'(outstanding), 64'd0);
        chk("t6_err_clear", 64'(err_underflow), 64'd0);
        pulse_resp();
        chk("t6_err_set", 64'(err_underflow), 64'd1);
        chk("t6_still_zero", 64'(outstanding), 64'd0);
        repeat (3) tick();
        chk("t6_err_sticky", 64'(err_underflow), 64'd1);

        // Reset while a grant is presented
        req_cyc = 2'b10;
        req_stb = 2'b10;
        tick();
        chk("t7_grant_stb", 64'(m_stb), 64'd1);
        a0 = ack_cnt;
        m_addr_ready = 1'b1;
        ARESETN = 1'b0;
        #1;
        chk("t7_rst_stb", 64'(m_stb), 64'd0);
        chk("t7_rst_cyc", 64'(m_cyc), 64'd0);
        chk("t7_rst_ack", 64'(req_ack), 64'd0);
        chk("t7_rst_outstanding", 64'(outstanding), 64'd0);
        chk("t7_rst_err", 64'(err_underflow), 64'd0);
        req_adr[31:0]  = 32'hA000;
        req_adr[63:32] = 32'hB000;
        req_cyc = 2'b11;
        req_stb = 2'b11;
        sb.push_back('{id: 4'd0, adr: 32'hA000});
        tick();
        chk("t7_no_ack_in_reset", 64'(ack_cnt - a0), 64'd0);
        ARESETN = 1'b1;
        tick();
        chk("t7_prio_stb", 64'(m_stb), 64'd1);
        chk("t7_prio_id", 64'(m_id), 64'd0);
        req_cyc = '0;
        req_stb = '0;
        tick();
        m_addr_ready = 1'b0;
        tick();
        chk("t7_ack_after", 64'(ack_cnt - a0), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
